rc4_prga_decoder: RTL and testbench
===================================

# rc4_prga_decoder

Parametrised RC4 keystream-generation and decryption engine, the next generation of the Lab 4 decode FSM. After an external controller has initialised and key-scheduled the 256-byte S memory, this block runs the RC4 PRGA over a `MSG_LEN`-byte encrypted ROM. It writes the plaintext to a decrypted-message RAM and flags keys that produce non-text output. It sits between the key-schedule FSM and the key-search controller, sharing the S memory port through the top-level mux.

## Interface
- `MSG_LEN`, 32: message length in bytes, 1..1024.
- `K_W`, `$clog2(MSG_LEN)` (minimum 1): width of the message index.
- `CHECK_EN`, 1: 1 enables the plaintext validity check; 0 means `bad_key` is never set.
- `ABORT_ON_BAD`, 1: 1 stops at the first invalid byte; 0 decrypts the whole message and only records the fault.

Ports:
- `clock` in 1: single clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level request to run.
- `s_address` out 8: S memory address.
- `s_data_in` in 8: S memory read data, 1-cycle read latency.
- `s_data_out` out 8: S memory write data.
- `s_write_enable` out 1: S memory write strobe.
- `rom_address` out K_W: encrypted ROM address.
- `rom_data` in 8: ROM data, 1-cycle latency.
- `dec_address` out K_W: decrypted RAM address.
- `dec_data` out 8: plaintext byte.
- `dec_write_enable` out 1: decrypted RAM write strobe.
- `done` out 1: run finished (level).
- `bad_key` out 1: an invalid plaintext byte was produced.
- `bad_index` out K_W: index of the first invalid byte.

## Operation
- Internal registers: `i`, `j`, `si`, `sj`, `f`, `enc` are 8 bits; `k` is K_W bits. All 8-bit arithmetic is mod 256 and wraps silently.
- States: IDLE, FETCH_I, LATCH_I, FETCH_J, LATCH_J, SWAP_I, SWAP_J, FETCH_F, LATCH_F, WRITE_OUT, DONE.
- IDLE to FETCH_I: taken when `start`=1. On this transition: `i`←1, `j`←0, `k`←0; clear `done`, `bad_key`, `bad_index`.
- FETCH_I: `s_address`=`i`, `rom_address`=`k`.
- LATCH_I: `si`←`s_data_in`, `enc`←`rom_data`, `j`←`j`+`s_data_in`.
- FETCH_J: `s_address`=`j`.
- LATCH_J: `sj`←`s_data_in`.
- SWAP_I: write S[`i`]←`sj`.
- SWAP_J: write S[`j`]←`si`.
  - When `i`=`j`, both writes hit the same address. Both carry the same value, so no special case is needed.
- FETCH_F: `s_address`=`si`+`sj` (8-bit). The read sees the post-swap contents.
- LATCH_F: `f`←`s_data_in`.
- WRITE_OUT actions, all in the same cycle:
  - `dec_address`=`k`, `dec_data`=`f`^`enc`, `dec_write_enable`=1.
  - Byte is valid if it is 0x61..0x7A or 0x20.
  - If `CHECK_EN` and the byte is invalid and `bad_key`=0: set `bad_key`←1 and `bad_index`←`k`.
- WRITE_OUT next state:
  - DONE if the byte was invalid with `CHECK_EN`=1 and `ABORT_ON_BAD`=1.
  - DONE if `k`=`MSG_LEN`-1.
  - Otherwise FETCH_I, with `k`←`k`+1 and `i`←`i`+1.
- DONE: `done`=1; `bad_key` and `bad_index` are held. Return to IDLE when `start`=0. The outputs stay valid in IDLE until the next run starts.
- Write ports are one-hot: `s_write_enable` and `dec_write_enable` are never asserted together, and neither is asserted outside SWAP_I, SWAP_J or WRITE_OUT.

## Timing
- Reset values: state=IDLE; all outputs 0, including `done`, `bad_key`, `bad_index`, all addresses and data, and both write enables.
- Reset mid-run: the block is in IDLE on the next edge and no further writes occur. S memory may be left partially swapped; the controller must re-run the key schedule.
- Throughput: 9 cycles per byte.
- Latency, with `start` sampled at edge T0:
  - Byte n is written during cycle 9n+9.
  - `done` rises at edge T0+9·`MSG_LEN`+1.
  - On abort at byte n, `done` rises at T0+9n+10.
- `start` held high after DONE does not retrigger. It must drop to 0 for at least one cycle first.
- Addresses are combinational from state and registers and are valid for the whole cycle. Read data is sampled in the following state.

## Test plan
- `MSG_LEN`=1, S identity, ROM[0]=0x63:
  - `s_address` sequence is 1, 1, (write 1), (write 1), 2.
  - `dec_data`=0x61 at `dec_address` 0.
  - `done` at T0+10, `bad_key`=0.
- `MSG_LEN`=2, S identity, ROM={0x63,0x25}:
  - Byte 1: `i`=2, `j`=3; swap gives S[2]=3, S[3]=2; f=S[5]=5.
  - `dec_data`=0x20, `bad_key`=0, `done` at T0+19.
- `MSG_LEN`=4, S identity, ROM={0x63,0x65,…}, `ABORT_ON_BAD`=1:
  - Byte 1 decrypts to 0x60, giving `bad_key`=1, `bad_index`=1.
  - `done` at T0+19; no write to `dec_address` 2.
- Same stimulus with `ABORT_ON_BAD`=0: 4 writes, `done` at T0+37, `bad_key`=1, `bad_index`=1. With `CHECK_EN`=0: `bad_key`=0.
- `MSG_LEN`=256: byte 255 issues `s_address`=0 in FETCH_I, confirming `i` wraps. Output matches the reference-model keystream.
- Reset:
  - Assert `reset` at cycle 5 of a run: all outputs are 0 on the next edge, and there are no writes until a new `start`.
  - Hold `start`=1 through DONE: no second run occurs.

Source files
------------

// File: rtl/rc4_prga_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rc4_prga_decoder
// Description : RC4 pseudo-random generation (PRGA) and decryption engine.
//               Runs over a key-scheduled 256-byte S memory and a MSG_LEN-byte
//               encrypted ROM, writes plaintext to a decrypted-message RAM and
//               flags keys that yield bytes outside [a-z] / space.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   rising-edge clock
//   reset            in   synchronous active-high reset
//   start            in   level run request
//   s_address        out  S memory address (combinational)
//   s_data_in        in   S memory read data, 1-cycle latency
//   s_data_out       out  S memory write data
//   s_write_enable   out  S memory write strobe
//   rom_address      out  encrypted ROM address
//   rom_data         in   encrypted ROM data, 1-cycle latency
//   dec_address      out  decrypted RAM address
//   dec_data         out  plaintext byte
//   dec_write_enable out  decrypted RAM write strobe
//   done             out  run finished (held until the next run starts)
//   bad_key          out  an invalid plaintext byte was produced
//   bad_index        out  message index of the first invalid byte
// ============================================================================
module rc4_prga_decoder #(
    parameter int MSG_LEN      = 32,
    parameter int K_W          = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    parameter bit CHECK_EN     = 1'b1,
    parameter bit ABORT_ON_BAD = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    output logic [7:0]     s_address,
    input  logic [7:0]     s_data_in,
    output logic [7:0]     s_data_out,
    output logic           s_write_enable,
    output logic [K_W-1:0] rom_address,
    input  logic [7:0]     rom_data,
    output logic [K_W-1:0] dec_address,
    output logic [7:0]     dec_data,
    output logic           dec_write_enable,
    output logic           done,
    output logic           bad_key,
    output logic [K_W-1:0] bad_index
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH_I   = 4'd1,
        LATCH_I   = 4'd2,
        FETCH_J   = 4'd3,
        LATCH_J   = 4'd4,
        SWAP_I    = 4'd5,
        SWAP_J    = 4'd6,
        FETCH_F   = 4'd7,
        LATCH_F   = 4'd8,
        WRITE_OUT = 4'd9,
        DONE      = 4'd10
    } state_t;

    localparam logic [K_W-1:0] C_LAST_K = K_W'(MSG_LEN - 1);
    localparam logic [K_W-1:0] C_K_ONE  = K_W'(1);

    state_t         state_q, state_d;
    logic [7:0]     i_q, i_d;
    logic [7:0]     j_q, j_d;
    logic [7:0]     si_q, si_d;
    logic [7:0]     sj_q, sj_d;
    logic [7:0]     f_q, f_d;
    logic [7:0]     enc_q, enc_d;
    logic [K_W-1:0] k_q, k_d;
    logic           done_q, done_d;
    logic           bad_key_q, bad_key_d;
    logic [K_W-1:0] bad_index_q, bad_index_d;

    logic [7:0]     w_plain;
    logic           w_valid;
    logic           w_bad_byte;

    // Plaintext classification of the byte being written this cycle.
    assign w_plain    = f_q ^ enc_q;
    assign w_valid    = ((w_plain >= 8'h61) && (w_plain <= 8'h7A)) || (w_plain == 8'h20);
    assign w_bad_byte = CHECK_EN && !w_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            f_q         <= 8'd0;
            enc_q       <= 8'd0;
            k_q         <= '0;
            done_q      <= 1'b0;
            bad_key_q   <= 1'b0;
            bad_index_q <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            f_q         <= f_d;
            enc_q       <= enc_d;
            k_q         <= k_d;
            done_q      <= done_d;
            bad_key_q   <= bad_key_d;
            bad_index_q <= bad_index_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        i_d              = i_q;
        j_d              = j_q;
        si_d             = si_q;
        sj_d             = sj_q;
        f_d              = f_q;
        enc_d            = enc_q;
        k_d              = k_q;
        done_d           = done_q;
        bad_key_d        = bad_key_q;
        bad_index_d      = bad_index_q;

        s_address        = 8'd0;
        s_data_out       = 8'd0;
        s_write_enable   = 1'b0;
        rom_address      = '0;
        dec_address      = '0;
        dec_data         = 8'd0;
        dec_write_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH_I;
                    i_d         = 8'd1;
                    j_d         = 8'd0;
                    k_d         = '0;
                    done_d      = 1'b0;
                    bad_key_d   = 1'b0;
                    bad_index_d = '0;
                end
            end
            FETCH_I: begin
                s_address   = i_q;
                rom_address = k_q;
                state_d     = LATCH_I;
            end
            LATCH_I: begin
                si_d    = s_data_in;
                enc_d   = rom_data;
                j_d     = j_q + s_data_in;
                state_d = FETCH_J;
            end
            FETCH_J: begin
                s_address = j_q;
                state_d   = LATCH_J;
            end
            LATCH_J: begin
                sj_d    = s_data_in;
                state_d = SWAP_I;
            end
            // When i == j both writes target one address with the same value,
            // so the swap needs no special case.
            SWAP_I: begin
                s_address      = i_q;
                s_data_out     = sj_q;
                s_write_enable = 1'b1;
                state_d        = SWAP_J;
            end
            SWAP_J: begin
                s_address      = j_q;
                s_data_out     = si_q;
                s_write_enable = 1'b1;
                state_d        = FETCH_F;
            end
            // si + sj equals S[i] + S[j] after the swap; the read returns the
            // post-swap contents because both writes have already landed.
            FETCH_F: begin
                s_address = si_q + sj_q;
                state_d   = LATCH_F;
            end
            LATCH_F: begin
                f_d     = s_data_in;
                state_d = WRITE_OUT;
            end
            WRITE_OUT: begin
                dec_address      = k_q;
                dec_data         = w_plain;
                dec_write_enable = 1'b1;
                if (w_bad_byte && !bad_key_q) begin
                    bad_key_d   = 1'b1;
                    bad_index_d = k_q;
                end
                if ((w_bad_byte && ABORT_ON_BAD) || (k_q == C_LAST_K)) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + C_K_ONE;
                    i_d     = i_q + 8'd1;
                    state_d = FETCH_I;
                end
            end
            // Waiting for start to drop prevents a held start from retriggering.
            DONE: begin
                done_d = 1'b1;
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done      = done_q;
    assign bad_key   = bad_key_q;
    assign bad_index = bad_index_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc4_prga_decoder
// Description : Self-checking bench for rc4_prga_decoder. Several instances
//               with different MSG_LEN / CHECK_EN / ABORT_ON_BAD settings share
//               one clock; each has its own S memory and ROM model. Results
//               are compared against a plain RC4 reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_prga_decoder;

    localparam int NI = 6;
    // instance:                      0  1  2  3  4    5
    localparam int CFG_LEN [NI] = '{1, 4, 4, 4, 256, 2};
    localparam logic [NI-1:0] CFG_CHK = 6'b110111;  // instance 3: check off
    localparam logic [NI-1:0] CFG_ABT = 6'b101011;  // instances 2,4: no abort

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [NI-1:0]      rst_v, start_v, s_we, dec_we, done_v, bad_v;
    logic [NI-1:0][7:0] s_addr, s_din, s_dout, rom_addr, rom_d, dec_addr, dec_d, bidx_v;

    logic [7:0] smem  [NI][256];
    logic [7:0] rmem  [NI][256];
    logic [7:0] sload [256];
    int         ld_g   = 0;
    logic       ld_req = 1'b0;

    int vectors = 0;
    int errors  = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int ML = CFG_LEN[g];
        localparam int KW = (ML > 1) ? $clog2(ML) : 1;
        logic [KW-1:0] rom_a, dec_a, bidx;
        rc4_prga_decoder #(
            .MSG_LEN(ML), .K_W(KW), .CHECK_EN(CFG_CHK[g]), .ABORT_ON_BAD(CFG_ABT[g])
        ) u_dut (
            .clock(clock), .reset(rst_v[g]), .start(start_v[g]),
            .s_address(s_addr[g]), .s_data_in(s_din[g]), .s_data_out(s_dout[g]),
            .s_write_enable(s_we[g]), .rom_address(rom_a), .rom_data(rom_d[g]),
            .dec_address(dec_a), .dec_data(dec_d[g]), .dec_write_enable(dec_we[g]),
            .done(done_v[g]), .bad_key(bad_v[g]), .bad_index(bidx)
        );
        assign rom_addr[g] = 8'(rom_a);
        assign dec_addr[g] = 8'(dec_a);
        assign bidx_v[g]   = 8'(bidx);
    end

    // Synchronous memories with 1-cycle read latency; bulk S loads come from sload.
    always @(posedge clock) begin
        for (int g = 0; g < NI; g++) begin
            s_din[g] <= smem[g][s_addr[g]];
            rom_d[g] <= rmem[g][rom_addr[g]];
            if (s_we[g]) smem[g][s_addr[g]] <= s_dout[g];
        end
        if (ld_req) begin
            for (int k = 0; k < 256; k++) smem[ld_g][k] <= sload[k];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] m_pt   [256];
    logic [7:0] m_sfin [256];
    int         m_nwr, m_bidx, m_done;
    bit         m_bad;

    task automatic model(input int g, input int len, input bit chk, input bit abt);
        logic [7:0] s [256];
        logic [7:0] i, j, t, p;
        bit ok;
        for (int k = 0; k < 256; k++) s[k] = smem[g][k];
        i = 8'd0; j = 8'd0; m_bad = 1'b0; m_bidx = 0; m_nwr = 0;
        for (int n = 0; n < len; n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            p = s[8'(s[i] + s[j])] ^ rmem[g][n];
            m_pt[n] = p;
            m_nwr   = n + 1;
            ok = ((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20);
            if (chk && !ok && !m_bad) begin m_bad = 1'b1; m_bidx = n; end
            if (chk && !ok && abt) break;
        end
        m_done = 9 * m_nwr + 1;
        for (int k = 0; k < 256; k++) m_sfin[k] = s[k];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic load_s(input int g);
        ld_g = g; ld_req = 1'b1;
        @(negedge clock);
        ld_req = 1'b0;
    endtask

    task automatic load_identity(input int g);
        for (int k = 0; k < 256; k++) sload[k] = 8'(k);
        load_s(g);
    endtask

    task automatic load_perm(input int g);
        logic [7:0] t;
        int r;
        for (int k = 0; k < 256; k++) sload[k] = 8'(k);
        for (int k = 255; k > 0; k--) begin
            r = $urandom_range(k, 0);
            t = sload[k]; sload[k] = sload[r]; sload[r] = t;
        end
        load_s(g);
    endtask

    // ROM whose plaintext under the current S is random lowercase/space text.
    task automatic load_text_rom(input int g, input int len);
        logic [7:0] ch;
        for (int n = 0; n < 256; n++) rmem[g][n] = 8'h00;
        model(g, len, 1'b0, 1'b0);
        for (int n = 0; n < len; n++) begin
            ch = ($urandom_range(7, 0) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(25, 0));
            rmem[g][n] = m_pt[n] ^ ch;
        end
    endtask

    // Observation of one run (no checking here).
    int         obs_done, obs_overlap;
    int         obs_wc [$];
    logic [7:0] obs_wa [$];
    logic [7:0] obs_wd [$];
    logic [7:0] obs_sa [$];
    logic       obs_swe [$];

    task automatic run(input int g, input int budget);
        obs_wc.delete(); obs_wa.delete(); obs_wd.delete(); obs_sa.delete(); obs_swe.delete();
        obs_done = -1; obs_overlap = 0;
        @(negedge clock);
        start_v[g] = 1'b1;
        @(posedge clock);                       // edge T0
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock);                   // sample cycle c
            if (s_we[g] && dec_we[g]) obs_overlap++;
            obs_sa.push_back(s_addr[g]);
            obs_swe.push_back(s_we[g]);
            if (dec_we[g]) begin
                obs_wa.push_back(dec_addr[g]); obs_wd.push_back(dec_d[g]); obs_wc.push_back(c);
            end
            if (done_v[g]) begin obs_done = c - 1; break; end
        end
    endtask

    task automatic finish_run(input int g);
        start_v[g] = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [51:0] o;
        rst_v = '1; start_v = '0;
        repeat (3) @(negedge clock);
        for (int g = 0; g < NI; g++) begin
            o = {done_v[g], bad_v[g], s_we[g], dec_we[g], s_addr[g], s_dout[g],
                 rom_addr[g], dec_addr[g], dec_d[g], bidx_v[g]};
            vectors++;
            if (o !== 52'h0) begin errors++; $display("FAIL reset_outputs inst %0d: got %h expected 0", g, o); end
        end
        rst_v = '0;
        @(negedge clock);
    endtask

    task automatic test_single_byte();
        int nswe;
        load_identity(0);
        for (int n = 0; n < 256; n++) rmem[0][n] = 8'h00;
        rmem[0][0] = 8'h63;
        run(0, 40);
        vectors++;
        if (obs_sa.size() < 7 || obs_sa[0] !== 8'd1 || obs_sa[2] !== 8'd1 || obs_sa[4] !== 8'd1 ||
            obs_sa[5] !== 8'd1 || obs_sa[6] !== 8'd2) begin
            errors++; $display("FAIL s_addr_seq: got size %0d, expected 1,1,1,1,2 in cycles 1,3,5,6,7", obs_sa.size());
        end
        nswe = 0;
        foreach (obs_swe[c]) if (obs_swe[c]) nswe++;
        vectors++;
        if (nswe != 2 || obs_swe.size() < 6 || obs_swe[4] !== 1'b1 || obs_swe[5] !== 1'b1) begin
            errors++; $display("FAIL s_write_cycles: got %0d writes, expected 2 in cycles 5,6", nswe);
        end
        vectors++;
        if (obs_wa.size() != 1 || obs_wa[0] !== 8'd0 || obs_wd[0] !== 8'h61 || obs_wc[0] != 9) begin
            errors++; $display("FAIL single_write: got %0d writes, expected one 0x61 at addr 0 in cycle 9", obs_wa.size());
        end
        vectors++;
        if (obs_done != 10) begin errors++; $display("FAIL single_done: got %0d expected 10", obs_done); end
        vectors++;
        if (bad_v[0] !== 1'b0 || obs_overlap != 0) begin
            errors++; $display("FAIL single_flags: bad_key %b overlap %0d, expected 0 and 0", bad_v[0], obs_overlap);
        end
        finish_run(0);
    endtask

    task automatic test_two_bytes();
        load_identity(5);
        for (int n = 0; n < 256; n++) rmem[5][n] = 8'h00;
        rmem[5][0] = 8'h63; rmem[5][1] = 8'h25;
        model(5, 2, 1'b1, 1'b1);
        run(5, 60);
        vectors++;
        if (obs_wa.size() != 2 || obs_wd[0] !== 8'h61 || obs_wd[1] !== 8'h20 || obs_wa[1] !== 8'd1 ||
            obs_wc[1] != 18) begin
            errors++; $display("FAIL two_bytes_data: got %0d writes, expected 0x61,0x20 with byte1 in cycle 18", obs_wa.size());
        end
        vectors++;
        if (obs_done != 19 || bad_v[5] !== 1'b0) begin
            errors++; $display("FAIL two_bytes_done: got done %0d bad %b, expected 19 and 0", obs_done, bad_v[5]);
        end
        finish_run(5);
        vectors++;
        if (smem[5][2] !== 8'd3 || smem[5][3] !== 8'd2) begin
            errors++; $display("FAIL two_bytes_swap: got S[2]=%0d S[3]=%0d expected 3 and 2", smem[5][2], smem[5][3]);
        end
    endtask

    // Same ROM on instances 1 (abort), 2 (no abort), 3 (check disabled).
    task automatic test_bad_byte_policy();
        int exp_n    [3] = '{2, 4, 4};
        int exp_done [3] = '{19, 37, 37};
        bit exp_bad  [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] r2, r3;
        r2 = 8'($urandom); r3 = 8'($urandom);
        for (int t = 0; t < 3; t++) begin
            int g = t + 1;
            load_identity(g);
            for (int n = 0; n < 256; n++) rmem[g][n] = 8'h00;
            rmem[g][0] = 8'h63; rmem[g][1] = 8'h65; rmem[g][2] = r2; rmem[g][3] = r3;
            model(g, 4, CFG_CHK[g], CFG_ABT[g]);
            run(g, 80);
            vectors++;
            if (obs_wa.size() != exp_n[t]) begin
                errors++; $display("FAIL policy_count inst %0d: got %0d writes expected %0d", g, obs_wa.size(), exp_n[t]);
            end
            for (int n = 0; n < exp_n[t] && n < obs_wa.size(); n++) begin
                vectors++;
                if (obs_wa[n] !== 8'(n) || obs_wd[n] !== m_pt[n] || obs_wc[n] != 9 * n + 9) begin
                    errors++; $display("FAIL policy_byte inst %0d n %0d: got %h@%0d expected %h@%0d", g, n, obs_wd[n], obs_wc[n], m_pt[n], 9 * n + 9);
                end
            end
            vectors++;
            if (obs_done != exp_done[t]) begin
                errors++; $display("FAIL policy_done inst %0d: got %0d expected %0d", g, obs_done, exp_done[t]);
            end
            vectors++;
            if (bad_v[g] !== exp_bad[t] || bidx_v[g] !== (exp_bad[t] ? 8'd1 : 8'd0) || (t == 0 && m_pt[1] !== 8'h60)) begin
                errors++; $display("FAIL policy_flags inst %0d: got bad %b idx %0d expected %b", g, bad_v[g], bidx_v[g], exp_bad[t]);
            end
            finish_run(g);
        end
    endtask

    task automatic test_keystream_256();
        int bp, nbad;
        load_perm(4);
        load_text_rom(4, 256);
        bp = $urandom_range(255, 0);
        rmem[4][bp] = m_pt[bp] ^ 8'(8'h41 + $urandom_range(25, 0));  // uppercase: invalid
        model(4, 256, 1'b1, 1'b0);
        run(4, 2400);
        vectors++;
        if (obs_wa.size() != 256) begin errors++; $display("FAIL ks_count: got %0d expected 256", obs_wa.size()); end
        for (int n = 0; n < 256 && n < obs_wa.size(); n++) begin
            vectors++;
            if (obs_wa[n] !== 8'(n) || obs_wd[n] !== m_pt[n] || obs_wc[n] != 9 * n + 9) begin
                errors++; $display("FAIL ks_byte n %0d: got %h@%0d expected %h@%0d", n, obs_wd[n], obs_wc[n], m_pt[n], 9 * n + 9);
            end
        end
        vectors++;
        if (obs_done != 2305) begin errors++; $display("FAIL ks_done: got %0d expected 2305", obs_done); end
        vectors++;
        if (obs_sa.size() < 2296 || obs_sa[2295] !== 8'd0) begin
            errors++; $display("FAIL ks_i_wrap: s_address at byte 255 FETCH_I not 0 (size %0d)", obs_sa.size());
        end
        vectors++;
        if (bad_v[4] !== 1'b1 || bidx_v[4] !== 8'(bp) || obs_overlap != 0) begin
            errors++; $display("FAIL ks_flags: got bad %b idx %0d overlap %0d expected 1 %0d 0", bad_v[4], bidx_v[4], obs_overlap, bp);
        end
        finish_run(4);
        nbad = 0;
        for (int k = 0; k < 256; k++) if (smem[4][k] !== m_sfin[k]) nbad++;
        vectors++;
        if (nbad != 0) begin errors++; $display("FAIL ks_final_s: got %0d differing bytes expected 0", nbad); end
    endtask

    task automatic test_hold_start();
        int extra;
        load_identity(0);
        for (int n = 0; n < 256; n++) rmem[0][n] = 8'h00;
        rmem[0][0] = 8'h63;
        run(0, 40);
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (s_we[0] || dec_we[0] || !done_v[0]) extra++;
        end
        vectors++;
        if (extra != 0) begin errors++; $display("FAIL hold_no_retrigger: got %0d bad cycles expected 0", extra); end
        start_v[0] = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if (done_v[0] !== 1'b1 || bad_v[0] !== 1'b0) begin
            errors++; $display("FAIL idle_hold: got done %b bad %b expected 1 0", done_v[0], bad_v[0]);
        end
        run(0, 40);
        vectors++;
        if (obs_done != 10) begin errors++; $display("FAIL rerun_done: got %0d expected 10", obs_done); end
        finish_run(0);
    endtask

    task automatic test_mid_reset();
        logic [51:0] o;
        int extra;
        load_identity(2);
        for (int n = 0; n < 256; n++) rmem[2][n] = 8'($urandom);
        @(negedge clock);
        start_v[2] = 1'b1;
        @(posedge clock);
        repeat (5) @(negedge clock);
        rst_v[2] = 1'b1; start_v[2] = 1'b0;
        @(negedge clock);
        o = {done_v[2], bad_v[2], s_we[2], dec_we[2], s_addr[2], s_dout[2],
             rom_addr[2], dec_addr[2], dec_d[2], bidx_v[2]};
        vectors++;
        if (o !== 52'h0) begin errors++; $display("FAIL midrun_reset_outputs: got %h expected 0", o); end
        rst_v[2] = 1'b0;
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (s_we[2] || dec_we[2]) extra++;
        end
        vectors++;
        if (extra != 0) begin errors++; $display("FAIL midrun_no_writes: got %0d expected 0", extra); end
        load_identity(2);
        model(2, 4, 1'b1, 1'b0);
        run(2, 80);
        vectors++;
        if (obs_done != m_done || obs_wa.size() != 4 || obs_wd[3] !== m_pt[3]) begin
            errors++; $display("FAIL recover_run: got done %0d writes %0d expected %0d 4", obs_done, obs_wa.size(), m_done);
        end
        finish_run(2);
    endtask

    task automatic test_back_to_back();
        load_perm(5);
        for (int it = 0; it < 3; it++) begin
            if (it == 1) for (int n = 0; n < 256; n++) rmem[5][n] = 8'($urandom);
            else load_text_rom(5, 2);
            model(5, 2, 1'b1, 1'b1);
            run(5, 60);
            vectors++;
            if (obs_wa.size() != m_nwr) begin
                errors++; $display("FAIL b2b_count it %0d: got %0d expected %0d", it, obs_wa.size(), m_nwr);
            end
            for (int n = 0; n < m_nwr && n < obs_wa.size(); n++) begin
                vectors++;
                if (obs_wa[n] !== 8'(n) || obs_wd[n] !== m_pt[n]) begin
                    errors++; $display("FAIL b2b_byte it %0d n %0d: got %h expected %h", it, n, obs_wd[n], m_pt[n]);
                end
            end
            vectors++;
            if (obs_done != m_done || bad_v[5] !== m_bad || bidx_v[5] !== 8'(m_bidx)) begin
                errors++; $display("FAIL b2b_status it %0d: got done %0d bad %b idx %0d expected %0d %b %0d", it, obs_done, bad_v[5], bidx_v[5], m_done, m_bad, m_bidx);
            end
            start_v[5] = 1'b0;                  // low for exactly one cycle
        end
        finish_run(5);
    endtask

    initial begin
        rst_v = '1; start_v = '0;
        test_reset();
        test_single_byte();
        test_two_bytes();
        test_bad_byte_policy();
        test_keystream_256();
        test_hold_start();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
